pixel_enhance_stream: RTL
=========================

Name: pixel_enhance_stream

Overview:
- Parametrised streaming successor to the fixed-size, single-mode image processing path.
- Accepts multi-channel pixels over a valid/ready handshake and applies a run-time selected enhancement to every channel. Modes: pass-through, saturating brightness add/subtract, binary threshold, with optional inversion.
- Owns the start/busy/done control sequence and the pixel counter, and ends the frame after TOTAL_PIXELS accepted pixels.
- Sits between the image file reader and the BMP writer.

Parameters:
- DATA_W, 8: bits per channel sample.
- CHANNELS, 3: samples per pixel (1 = grayscale, 3 = BGR).
- TOTAL_PIXELS, 120000: pixels per frame. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 32: pixel counter width.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame start request; sampled only in IDLE or DONE.
- mode  in  2  00 pass, 01 add, 10 subtract, 11 threshold; latched on start.
- invert  in  1  bitwise-invert the result after mode; latched on start.
- value  in  DATA_W  brightness offset or threshold level; latched on start.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel this cycle.
- in_data  in  CHANNELS*DATA_W  input pixel; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_data  out  CHANNELS*DATA_W  processed pixel, same packing as in_data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level, high in DONE.
- pixel_count  out  CNT_W  number of input pixels accepted in the current frame.

Behaviour:
- Reset: state is IDLE. in_ready, out_valid, busy and done are 0; out_data, pixel_count and latched config are 0.
- Reset takes priority over all other inputs, including mid-frame. Any in-flight output is discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready = 0.
  - start = 1 latches mode, invert and value, clears pixel_count, and moves to RUN on the next cycle.
- RUN:
  - in_ready = !out_valid || out_ready (single output register, no combinational path from in_data to out_data).
  - An input is accepted when in_valid && in_ready. On acceptance:
    - out_data is loaded with the processed pixel;
    - out_valid is set to 1;
    - pixel_count is incremented.
  - Latency is 1 cycle from accept to out_valid.
  - If out_valid && out_ready and no input is accepted, out_valid is cleared.
  - out_data is held stable while out_valid && !out_ready.
  - When an acceptance makes pixel_count equal TOTAL_PIXELS, the next state is DRAIN.
- DRAIN:
  - in_ready = 0.
  - When out_valid && out_ready (or out_valid is already 0), out_valid is cleared and the next state is DONE.
- DONE:
  - done = 1, busy = 0, in_ready = 0.
  - pixel_count holds at TOTAL_PIXELS.
  - start = 1 relatches config, clears pixel_count and done, and moves to RUN.
- start is ignored in RUN and DRAIN. The config inputs are ignored except in the cycle where start is accepted.
- Per-channel arithmetic; channels are independent and use latched config:
  - 00: r = p.
  - 01: r = min(p + value, 2^DATA_W - 1), computed at DATA_W+1 bits.
  - 10: r = max(p - value, 0). No wrap-around.
  - 11: r = (p >= value) ? all-ones : 0.
  - If invert = 1, out = ~r; otherwise out = r.
- Input presented while in_ready = 0 is not consumed. The source must hold it.
- out_valid never drops without a handshake, except on reset.
- With TOTAL_PIXELS = 1, the first accepted pixel moves the block straight to DRAIN.

Test Plan:
All scenarios use CHANNELS=3, DATA_W=8, TOTAL_PIXELS=4, out_ready=1 unless stated.
1. Mode 01, value 0x40, pixel {0x10,0xC0,0xFF}: out {0x50,0xFF,0xFF} one cycle after accept. After 4 pixels, done=1 and pixel_count=4.
2. Mode 10, value 0x20, pixel {0x30,0x10,0x00}: out {0x10,0x00,0x00}. Mode 11, value 0x80, pixel {0x7F,0x80,0xFF}: out {0x00,0xFF,0xFF}. Same threshold case with invert=1: {0xFF,0x00,0x00}.
3. Backpressure: out_ready=0 for 5 cycles after the first output. in_ready=0 throughout, out_data stays constant, and no pixel is lost or duplicated across the 4-pixel frame.
4. Drain: the last pixel is accepted with out_ready=0 for 3 cycles. State stays DRAIN and done=0 until the handshake, then done=1 on the following cycle.
5. Restart and config latching: start in DONE with mode 00 gives pixel_count=0, busy=1, and a pass-through frame. Changing mode mid-frame has no effect, and start pulses during RUN are ignored.
6. Reset after 2 pixels with out_valid=1: on the next cycle out_valid=0, pixel_count=0, state IDLE, and in_ready=0 until a new start.

Source files
------------

// File: rtl/pixel_enhance_stream.sv
// Streaming per-channel pixel enhancement with frame control.
// Accepts pixels over valid/ready, applies pass/add/sub/threshold with optional
// inversion using configuration latched at frame start, and counts pixels until
// TOTAL_PIXELS have been accepted, then drains the output register and reports done.
module pixel_enhance_stream #(
  parameter int DATA_W       = 8,
  parameter int CHANNELS     = 3,
  parameter int TOTAL_PIXELS = 120000,
  parameter int CNT_W        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic                         invert,
  input  logic [DATA_W-1:0]            value,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             pixel_count
);

  localparam int PIX_W = CHANNELS * DATA_W;
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_PASS   = 2'b00,
    M_ADD    = 2'b01,
    M_SUB    = 2'b10,
    M_THRESH = 2'b11
  } mode_t;

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic                invert_q, invert_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic                out_valid_q, out_valid_d;
  logic [PIX_W-1:0]    out_data_q, out_data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    count_inc;
  logic                in_ready_c;
  logic [PIX_W-1:0]    proc_data;

  // Apply the latched enhancement to every channel independently.
  function automatic logic [PIX_W-1:0] enhance(
    input logic [PIX_W-1:0]  pix,
    input mode_t             m,
    input logic              inv,
    input logic [DATA_W-1:0] v
  );
    logic [PIX_W-1:0]  res;
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] r;
    logic [DATA_W:0]   sum;
    res = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      p   = pix[k*DATA_W +: DATA_W];
      sum = {1'b0, p} + {1'b0, v};
      case (m)
        M_PASS:   r = p;
        M_ADD:    r = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        M_SUB:    r = (p >= v) ? (p - v) : '0;
        M_THRESH: r = (p >= v) ? '1 : '0;
        default:  r = p;
      endcase
      res[k*DATA_W +: DATA_W] = inv ? ~r : r;
    end
    return res;
  endfunction

  // Datapath result for the pixel currently presented on in_data.
  always_comb begin
    proc_data = enhance(in_data, mode_q, invert_q, value_q);
  end

  assign count_inc = count_q + CNT_W'(1);

  // Next-state, handshake and register-update decisions.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    invert_d    = invert_q;
    value_d     = value_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    in_ready_c  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d   = mode_t'(mode);
          invert_d = invert;
          value_d  = value;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        in_ready_c = !out_valid_q || out_ready;
        if (in_valid && in_ready_c) begin
          out_data_d  = proc_data;
          out_valid_d = 1'b1;
          count_d     = count_inc;
          if (count_inc == TOTAL_C) begin
            state_d = S_DRAIN;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_PASS;
      invert_q    <= 1'b0;
      value_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      invert_q    <= invert_d;
      value_q     <= value_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
    end
  end

  assign in_ready    = in_ready_c;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign pixel_count = count_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

endmodule
